// File: rtl/led_sequencer.sv
// led_sequencer: programmable-rate LED pattern engine.
// A tick generator advances a pattern register in one of four modes:
// rotate-left, rotate-right, ping-pong and blink. The pattern drives o_led
// directly and is steered onto the per-colour outputs by i_color_sel.
// Optional build macro LED_SEQ_PWM_EN adds a free-running PWM dimmer that
// gates the colour outputs with i_duty. o_led is never dimmed.
//
// Mode register (mode_q) behaves as the FSM state:
//   state       | meaning
//   MODE_ROL    | rotate left on each tick, MSB wraps into LSB
//   MODE_ROR    | rotate right on each tick, LSB wraps into MSB
//   MODE_PING   | single lit LED bounces between the ends (dir_q tracks travel)
//   MODE_BLINK  | whole pattern toggles between all-off and all-on
// A change on i_mode restarts the new mode from its initial pattern.

module led_sequencer #(
  parameter int          NB_LEDS    = 4,
  parameter int          NB_COUNTER = 32,
  parameter int unsigned BASE_LIMIT = 2**20,
  parameter int          NB_DUTY    = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [2:0]         i_rate_sel,
  input  logic [1:0]         i_mode,
  input  logic [1:0]         i_color_sel,
  input  logic [NB_DUTY-1:0] i_duty,
  output logic [NB_LEDS-1:0] o_led,
  output logic [NB_LEDS-1:0] o_led_r,
  output logic [NB_LEDS-1:0] o_led_g,
  output logic [NB_LEDS-1:0] o_led_b,
  output logic               o_step
);

  typedef enum logic [1:0] {
    MODE_ROL   = 2'b00,
    MODE_ROR   = 2'b01,
    MODE_PING  = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Starting pattern of each mode; ping-pong starts at the LSB moving left.
  function automatic logic [NB_LEDS-1:0] init_pattern(input logic [1:0] mode);
    logic [NB_LEDS-1:0] p;
    p = '0;
    case (mode)
      2'b00, 2'b10: p[0]         = 1'b1;
      2'b01:        p[NB_LEDS-1] = 1'b1;
      default:      p            = '0;
    endcase
    return p;
  endfunction

  logic [NB_COUNTER-1:0] cnt_q, cnt_d;
  mode_e                 mode_q, mode_d;
  logic [NB_LEDS-1:0]    pat_q, pat_d;
  dir_e                  dir_q, dir_d;
  logic                  step_q, step_d;

  logic [NB_COUNTER-1:0] base_limit_c;
  logic [NB_COUNTER-1:0] limit_c;
  logic [NB_COUNTER-1:0] limit_m1_c;
  logic                  tick_c;
  logic                  mode_chg_c;
  logic [NB_LEDS-1:0]    gate_c;

  // Period compare uses >= so that lowering the rate below the running
  // count fires a tick immediately instead of waiting for a counter wrap.
  always_comb begin
    base_limit_c = NB_COUNTER'(BASE_LIMIT);
    limit_c      = base_limit_c << i_rate_sel;
    limit_m1_c   = limit_c - NB_COUNTER'(1);
    tick_c       = i_enable && (cnt_q >= limit_m1_c);
    mode_chg_c   = (mode_e'(i_mode) != mode_q);
  end

  // Next-state: a mode change wins over a tick; i_enable low freezes everything else.
  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    pat_d  = pat_q;
    dir_d  = dir_q;
    step_d = 1'b0;

    if (mode_chg_c) begin
      cnt_d  = '0;
      mode_d = mode_e'(i_mode);
      pat_d  = init_pattern(i_mode);
      dir_d  = DIR_LEFT;
    end else if (i_enable) begin
      if (tick_c) begin
        cnt_d  = '0;
        step_d = 1'b1;
        case (mode_q)
          MODE_ROL: pat_d = {pat_q[NB_LEDS-2:0], pat_q[NB_LEDS-1]};
          MODE_ROR: pat_d = {pat_q[0], pat_q[NB_LEDS-1:1]};
          MODE_PING: begin
            // Reverse and move on the same tick so the end LEDs dwell one period only.
            if (dir_q == DIR_LEFT) begin
              if (pat_q[NB_LEDS-1]) begin
                dir_d = DIR_RIGHT;
                pat_d = pat_q >> 1;
              end else begin
                pat_d = pat_q << 1;
              end
            end else begin
              if (pat_q[0]) begin
                dir_d = DIR_LEFT;
                pat_d = pat_q << 1;
              end else begin
                pat_d = pat_q >> 1;
              end
            end
          end
          MODE_BLINK: pat_d = ~pat_q;
          default:    pat_d = pat_q;
        endcase
      end else begin
        cnt_d = cnt_q + NB_COUNTER'(1);
      end
    end
  end

  // State registers with synchronous reset that loads the requested mode directly.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      cnt_q  <= '0;
      mode_q <= mode_e'(i_mode);
      pat_q  <= init_pattern(i_mode);
      dir_q  <= DIR_LEFT;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [NB_DUTY-1:0] pwm_cnt_q;

  // Free-running dimmer counter, independent of i_enable.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + NB_DUTY'(1);
    end
  end

  assign gate_c = {NB_LEDS{pwm_cnt_q < i_duty}};
`else
  logic unused_duty;

  assign unused_duty = ^i_duty;
  assign gate_c      = '1;
`endif

  // Colour steering: only the selected colour shows the pattern, 11 lights all three.
  always_comb begin
    o_led_r = '0;
    o_led_g = '0;
    o_led_b = '0;
    case (i_color_sel)
      2'b00: o_led_r = pat_q & gate_c;
      2'b01: o_led_g = pat_q & gate_c;
      2'b10: o_led_b = pat_q & gate_c;
      default: begin
        o_led_r = pat_q & gate_c;
        o_led_g = pat_q & gate_c;
        o_led_b = pat_q & gate_c;
      end
    endcase
  end

  assign o_led  = pat_q;
  assign o_step = step_q;

endmodule
